// File: rtl/osc_timebase_pkg.sv
// Shared definitions for the oscilloscope timebase controller:
// scale count, ms/div multiplier table and controller state encoding.
package osc_timebase_pkg;

   localparam int unsigned NUM_SCALES = 6;

   typedef enum logic [1:0] {
      RUN,
      PEND,
      APPLY
   } state_e;

   // Sample-period multiplier relative to the 0.1 ms/div setting
   function automatic int unsigned mult_of(input logic [2:0] idx);
      case (idx)
         3'd0:    return 1;
         3'd1:    return 2;
         3'd2:    return 5;
         3'd3:    return 10;
         3'd4:    return 20;
         default: return 50;
      endcase
   endfunction

endpackage

// File: rtl/osc_btn_edge.sv
// Registered rising-edge detector for a debounced button level.
module osc_btn_edge (
   input  logic clk,
   input  logic btn,
   output logic rise
);

   logic prev_q;

   // History follows the level even during reset, so a button held through
   // reset is never seen as a fresh press.
   always_ff @(posedge clk) begin
      prev_q <= btn;
   end

   assign rise = btn & ~prev_q;

endmodule

// File: rtl/timebase_scale_ctrl.sv
// Horizontal timebase controller: button-driven scale selection applied at
// VGA frame start, plus the ADC sample-enable divider for the active scale.
module timebase_scale_ctrl
   import osc_timebase_pkg::*;
#(
   parameter int unsigned BASE_DIV  = 100,
   parameter int unsigned RESET_IDX = 0,
   parameter int unsigned CNT_W     = 16
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       BTN_UP,
   input  logic       BTN_DOWN,
   input  logic       FRAME_START,
   output logic [2:0] LABEL_SEL,
   output logic       PENDING,
   output logic       SCALE_CHANGED,
   output logic       SAMPLE_EN
);

   localparam logic [2:0] RST_IDX = 3'(RESET_IDX);
   localparam logic [2:0] MAX_IDX = 3'(NUM_SCALES - 1);

   function automatic logic [CNT_W-1:0] reload_of(input logic [2:0] idx);
      int unsigned prod;
      prod = BASE_DIV * mult_of(idx);
      return CNT_W'(prod - 1);
   endfunction

   state_e           state_q, state_n;
   logic [2:0]       active_q, pend_q, pend_n;
   logic [CNT_W-1:0] cnt_q, cnt_n;
   logic             up_rise, dn_rise;

   osc_btn_edge u_edge_up (
      .clk  (CLK),
      .btn  (BTN_UP),
      .rise (up_rise)
   );

   osc_btn_edge u_edge_dn (
      .clk  (CLK),
      .btn  (BTN_DOWN),
      .rise (dn_rise)
   );

   always_comb begin
      pend_n = pend_q;
      if (up_rise && !dn_rise && pend_q != MAX_IDX) begin
         pend_n = pend_q + 3'd1;
      end else if (dn_rise && !up_rise && pend_q != '0) begin
         pend_n = pend_q - 3'd1;
      end
   end

   always_comb begin
      state_n = state_q;
      case (state_q)
         RUN: begin
            if (pend_q != active_q) state_n = PEND;
         end
         PEND: begin
            if (pend_q == active_q) state_n = RUN;
            else if (FRAME_START)   state_n = APPLY;
         end
         APPLY:   state_n = RUN;
         default: state_n = RUN;
      endcase
   end

   always_comb begin
      cnt_n = cnt_q;
      if (state_q == APPLY) begin
         cnt_n = reload_of(active_q);
      end else if (cnt_q == '0) begin
         cnt_n = reload_of(active_q);
      end else begin
         cnt_n = cnt_q - 1'b1;
      end
   end

   // Scale is latched on entry to APPLY and strobes are registered from the
   // next-state values, so LABEL_SEL, SCALE_CHANGED and SAMPLE_EN line up
   // with the cycle in which the state/counter they describe is current.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q       <= RUN;
         active_q      <= RST_IDX;
         pend_q        <= RST_IDX;
         cnt_q         <= reload_of(RST_IDX);
         PENDING       <= 1'b0;
         SCALE_CHANGED <= 1'b0;
         SAMPLE_EN     <= 1'b0;
      end else begin
         state_q       <= state_n;
         pend_q        <= pend_n;
         cnt_q         <= cnt_n;
         if (state_n == APPLY) active_q <= pend_q;
         PENDING       <= (state_n == PEND);
         SCALE_CHANGED <= (state_n == APPLY);
         SAMPLE_EN     <= (state_n != APPLY) && (cnt_n == '0);
      end
   end

   assign LABEL_SEL = active_q;

endmodule

// File: tb/tb_timebase_scale_ctrl.sv
// Scoreboard bench for timebase_scale_ctrl: a timestamp-based reference model
// queues expected status and strobe events, a monitor checks DUT outputs.
module tb_timebase_scale_ctrl;

   localparam int BASE_DIV  = 100;
   localparam int RESET_IDX = 0;
   localparam int CNT_W     = 16;

   logic       CLK, RESET, BTN_UP, BTN_DOWN, FRAME_START;
   logic [2:0] LABEL_SEL;
   logic       PENDING, SCALE_CHANGED, SAMPLE_EN;

   timebase_scale_ctrl #(
      .BASE_DIV  (BASE_DIV),
      .RESET_IDX (RESET_IDX),
      .CNT_W     (CNT_W)
   ) dut (
      .CLK           (CLK),
      .RESET         (RESET),
      .BTN_UP        (BTN_UP),
      .BTN_DOWN      (BTN_DOWN),
      .FRAME_START   (FRAME_START),
      .LABEL_SEL     (LABEL_SEL),
      .PENDING       (PENDING),
      .SCALE_CHANGED (SCALE_CHANGED),
      .SAMPLE_EN     (SAMPLE_EN)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   typedef struct {
      int         cyc;
      logic [2:0] label;
      logic       pending;
   } lvl_t;

   typedef struct {
      int         cyc;
      bit         is_change;
      logic [2:0] label;
   } evt_t;

   lvl_t lvl_q[$];
   evt_t evt_q[$];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   int mult_tab [6] = '{1, 2, 5, 10, 20, 50};

   function automatic int period_of(input int idx);
      return BASE_DIV * mult_tab[idx];
   endfunction

   // Reference model: scale indices as integers, sample times as absolute
   // cycle numbers; expectations are for the cycle after the current one.
   bit m_live, m_prev_up, m_prev_dn, m_pending, m_apply;
   bit up_e, dn_e, diff, apply_n, pending_n;
   int m_pend, m_active, m_next;
   lvl_t m_lvl;
   evt_t m_evt;

   initial begin
      m_live = 1'b0;
      forever begin
         @(posedge CLK);
         if (RESET) begin
            m_live    = 1'b1;
            m_pend    = RESET_IDX;
            m_active  = RESET_IDX;
            m_pending = 1'b0;
            m_apply   = 1'b0;
            m_next    = cyc + 1 + period_of(RESET_IDX) - 1;
            m_prev_up = BTN_UP;
            m_prev_dn = BTN_DOWN;
            m_lvl     = '{cyc + 1, 3'(RESET_IDX), 1'b0};
            lvl_q.push_back(m_lvl);
         end else if (m_live) begin
            up_e      = BTN_UP && !m_prev_up;
            dn_e      = BTN_DOWN && !m_prev_dn;
            m_prev_up = BTN_UP;
            m_prev_dn = BTN_DOWN;
            diff      = (m_pend != m_active);
            apply_n   = m_pending && FRAME_START && diff;
            pending_n = !m_apply && diff && !apply_n;
            if (apply_n) begin
               m_active = m_pend;
               m_next   = cyc + 2 + period_of(m_active) - 1;
               m_evt    = '{cyc + 1, 1'b1, 3'(m_active)};
               evt_q.push_back(m_evt);
            end else if (m_next == cyc + 1) begin
               m_evt  = '{cyc + 1, 1'b0, 3'(m_active)};
               evt_q.push_back(m_evt);
               m_next = m_next + period_of(m_active);
            end
            if (up_e && !dn_e)      m_pend = (m_pend < 5) ? m_pend + 1 : 5;
            else if (dn_e && !up_e) m_pend = (m_pend > 0) ? m_pend - 1 : 0;
            m_pending = pending_n;
            m_apply   = apply_n;
            m_lvl     = '{cyc + 1, 3'(m_active), pending_n};
            lvl_q.push_back(m_lvl);
         end
         cyc = cyc + 1;
      end
   end

   // Monitor: status every cycle, strobe events whenever the DUT pulses
   lvl_t l;
   evt_t e;
   bit   live_cyc;

   initial begin
      forever begin
         @(negedge CLK);
         live_cyc = 1'b0;
         if (lvl_q.size() > 0) begin
            l = lvl_q.pop_front();
            live_cyc = 1'b1;
            n_checks++;
            if (l.cyc != cyc || LABEL_SEL !== l.label || PENDING !== l.pending) begin
               n_fail++;
               $display("FAIL status cyc=%0d: LABEL_SEL=%0d PENDING=%b, required LABEL_SEL=%0d PENDING=%b (model cyc %0d)",
                        cyc, LABEL_SEL, PENDING, l.label, l.pending, l.cyc);
            end
         end
         while (evt_q.size() > 0 && evt_q[0].cyc < cyc) begin
            e = evt_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL missed_event: %s label=%0d required at cyc %0d, not seen",
                     e.is_change ? "SCALE_CHANGED" : "SAMPLE_EN", e.label, e.cyc);
         end
         if (live_cyc && (SAMPLE_EN !== 1'b0 || SCALE_CHANGED !== 1'b0)) begin
            n_checks++;
            if (evt_q.size() == 0 || evt_q[0].cyc != cyc) begin
               n_fail++;
               $display("FAIL unexpected_pulse cyc=%0d: SAMPLE_EN=%b SCALE_CHANGED=%b, required no pulse",
                        cyc, SAMPLE_EN, SCALE_CHANGED);
            end else begin
               e = evt_q.pop_front();
               if (SCALE_CHANGED !== e.is_change || SAMPLE_EN !== !e.is_change ||
                   LABEL_SEL !== e.label) begin
                  n_fail++;
                  $display("FAIL event cyc=%0d: SCALE_CHANGED=%b SAMPLE_EN=%b LABEL_SEL=%0d, required SCALE_CHANGED=%b SAMPLE_EN=%b LABEL_SEL=%0d",
                           cyc, SCALE_CHANGED, SAMPLE_EN, LABEL_SEL, e.is_change, !e.is_change, e.label);
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic press(input bit up);
      if (up) BTN_UP = 1'b1; else BTN_DOWN = 1'b1;
      tick(1 + $urandom_range(0, 3));
      if (up) BTN_UP = 1'b0; else BTN_DOWN = 1'b0;
      tick(1 + $urandom_range(0, 3));
   endtask

   task automatic frame();
      FRAME_START = 1'b1;
      tick(1);
      FRAME_START = 1'b0;
   endtask

   initial begin
      RESET = 1'b1; BTN_UP = 1'b1; BTN_DOWN = 1'b0; FRAME_START = 1'b0;
      tick(4);
      RESET = 1'b0;
      tick(120);
      BTN_UP = 1'b0;
      tick(100);
      frame();
      tick(30);

      BTN_UP = 1'b1; tick(1); BTN_UP = 1'b0;
      tick(49);
      frame();
      tick(600);

      repeat (7) press(1'b1);
      frame();
      tick(10200);
      repeat (2) press(1'b1);
      tick(20);
      frame();
      tick(20);

      press(1'b0);
      tick(5);
      press(1'b1);
      tick(10);
      frame();
      tick(50);

      BTN_UP = 1'b1; BTN_DOWN = 1'b1;
      tick(3);
      BTN_UP = 1'b0; BTN_DOWN = 1'b0;
      tick(5);
      frame();
      tick(20);

      BTN_DOWN = 1'b1; FRAME_START = 1'b1;
      tick(1);
      BTN_DOWN = 1'b0; FRAME_START = 1'b0;
      frame();
      tick(20);
      frame();
      tick(50);

      press(1'b0);
      tick(3);
      RESET = 1'b1;
      tick(2);
      RESET = 1'b0;
      tick(5);
      frame();
      tick(20);
      frame();
      tick(250);

      press(1'b1);
      tick(5);
      frame();
      RESET = 1'b1;
      tick(1);
      RESET = 1'b0;
      tick(250);

      repeat (3000) begin
         if ($urandom_range(0, 7) == 0) BTN_UP = ~BTN_UP;
         if ($urandom_range(0, 7) == 0) BTN_DOWN = ~BTN_DOWN;
         FRAME_START = ($urandom_range(0, 39) == 0);
         RESET = ($urandom_range(0, 999) == 0);
         tick(1);
      end
      BTN_UP = 1'b0; BTN_DOWN = 1'b0; FRAME_START = 1'b0; RESET = 1'b0;
      tick(30);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
